// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-scanning keypad front end with a per-key debouncer.
// Drives one row low at a time, synchronises the column returns and debounces
// every key on its own, so any number of simultaneous presses are reported.
// Outputs are a debounced key bitmap plus one-cycle press/release events.

module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 8
) (
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic [COLS-1:0]        keypad_col,
    output logic [ROWS-1:0]        keypad_row,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic [ROWS*COLS-1:0]   key_press,
    output logic [ROWS*COLS-1:0]   key_release,
    output logic                   any_key,
    output logic                   scan_done
);

    localparam int NK = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_FLIP   = CW'(DEBOUNCE - 1);

    logic [COLS-1:0] col_meta;
    logic [COLS-1:0] col_s;
    logic [RW-1:0]   row_ptr;
    logic [DW-1:0]   dwell;
    logic            strobe;

    logic [CW-1:0]   cnt     [NK];
    logic [CW-1:0]   cnt_nxt [NK];
    logic [NK-1:0]   state_nxt;
    logic [NK-1:0]   press_nxt;
    logic [NK-1:0]   release_nxt;

    // Two-flop synchroniser for the asynchronous column pins; resets to "open".
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= keypad_col;
            col_s    <= col_meta;
        end
    end

    // The last dwell cycle of each row is the sample strobe for that row.
    assign strobe = (dwell == LAST_DWELL);

    // Row sequencer: hold each row for SCAN_DIV cycles, then move to the next.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            row_ptr <= '0;
            dwell   <= '0;
        end else if (strobe) begin
            dwell   <= '0;
            row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    // One-cold row drive derived directly from the row pointer.
    always_comb begin
        keypad_row = ~(ROWS'(1) << row_ptr);
    end

    // Debounce decision for the keys of the active row on its strobe.
    always_comb begin
        state_nxt   = key_state;
        press_nxt   = '0;
        release_nxt = '0;
        for (int k = 0; k < NK; k++) begin
            cnt_nxt[k] = cnt[k];
        end
        if (strobe) begin
            for (int k = 0; k < NK; k++) begin
                if ((k / COLS) == int'(row_ptr)) begin
                    if (!col_s[k % COLS] == key_state[k]) begin
                        cnt_nxt[k] = '0;
                    end else if (cnt[k] == CNT_FLIP) begin
                        state_nxt[k]   = ~key_state[k];
                        cnt_nxt[k]     = '0;
                        press_nxt[k]   = ~key_state[k];
                        release_nxt[k] = key_state[k];
                    end else begin
                        cnt_nxt[k] = cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Register debounce state, event pulses and the end-of-scan marker.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_key     <= 1'b0;
            scan_done   <= 1'b0;
            for (int k = 0; k < NK; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            key_state   <= state_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            any_key     <= |state_nxt;
            scan_done   <= strobe && (row_ptr == LAST_ROW);
            for (int k = 0; k < NK; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

endmodule
